// File: rtl/axis_len_pkg.sv
// Shared constants and FSM state encoding for the AXIS length tagger.
// Stats counters in the tagger top are built only when STATS_EN is defined.
package axis_len_pkg;

    localparam int LEN_W       = 16;
    localparam int MAX_LEN_DEF = 2048;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        DISCARD = 2'd2
    } state_e;

endpackage

// File: rtl/axis_len_out_reg.sv
// One-deep AXIS output register slice: data/user/last/valid plus the
// upstream ready equation. Holds its payload stable while stalled.
module axis_len_out_reg
    import axis_len_pkg::*;
#(
    parameter int W = LEN_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [7:0]   i_data,
    input  logic [W-1:0] i_user,
    input  logic         i_last,
    input  logic         i_ready,
    output logic [7:0]   o_data,
    output logic [W-1:0] o_user,
    output logic         o_last,
    output logic         o_valid,
    output logic         o_ready
);

    logic [7:0]   data_q;
    logic [W-1:0] user_q;
    logic         last_q;
    logic         valid_q;

    assign o_ready = !valid_q || i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (i_load) begin
                data_q  <= i_data;
                user_q  <= i_user;
                last_q  <= i_last;
                valid_q <= 1'b1;
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_data  = data_q;
    assign o_user  = user_q;
    assign o_last  = last_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/axis_len_tagger.sv
// Tags a byte stream with its running frame length and truncates at MAX_LEN.
// Define STATS_EN to build the emitted/truncated frame counters.
module axis_len_tagger
    import axis_len_pkg::*;
#(
    parameter int MAX_LEN = axis_len_pkg::MAX_LEN_DEF,
    parameter int LEN_W   = axis_len_pkg::LEN_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_axis_data,
    input  logic             i_axis_valid,
    input  logic             i_axis_last,
    output logic             o_axis_ready,
    output logic [7:0]       o_axis_data,
    output logic [LEN_W-1:0] o_axis_user,
    output logic             o_axis_valid,
    output logic             o_axis_last,
    input  logic             i_axis_ready,
    output logic             o_trunc_pulse,
    output logic [31:0]      o_frame_cnt,
    output logic [31:0]      o_trunc_cnt
);

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic             trunc_q;
    logic             slice_ready;
    logic             in_fire;
    logic             load;
    logic             trunc;

    // DISCARD swallows the tail of an over-long frame regardless of downstream
    assign o_axis_ready = (state_q == DISCARD) || slice_ready;
    assign in_fire      = i_axis_valid && o_axis_ready;
    assign load         = in_fire && (state_q != DISCARD);
    assign cnt_d        = (state_q == IDLE) ? LEN_W'(1) : cnt_q + 1'b1;
    assign trunc        = load && !i_axis_last
                        && (cnt_d == LEN_W'(MAX_LEN));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= trunc;
            if (load) cnt_q <= cnt_d;
            unique case (state_q)
                IDLE, PASS: begin
                    if (load) begin
                        if (i_axis_last) state_q <= IDLE;
                        else if (trunc)  state_q <= DISCARD;
                        else             state_q <= PASS;
                    end
                end
                DISCARD: begin
                    if (in_fire && i_axis_last) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_len_out_reg #(.W(LEN_W)) u_out (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_data  (i_axis_data),
        .i_user  (cnt_d),
        .i_last  (i_axis_last || trunc),
        .i_ready (i_axis_ready),
        .o_data  (o_axis_data),
        .o_user  (o_axis_user),
        .o_last  (o_axis_last),
        .o_valid (o_axis_valid),
        .o_ready (slice_ready)
    );

    assign o_trunc_pulse = trunc_q;

`ifdef STATS_EN
    logic [31:0] frame_cnt_q;
    logic [31:0] trunc_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (o_axis_valid && i_axis_ready && o_axis_last)
                frame_cnt_q <= frame_cnt_q + 32'd1;
            if (trunc_q)
                trunc_cnt_q <= trunc_cnt_q + 32'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_trunc_cnt = trunc_cnt_q;
`else
    assign o_frame_cnt = '0;
    assign o_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_len_tagger.sv
// Randomized bench for axis_len_tagger against a frame-level reference model.
// Runs with MAX_LEN=16 so truncation is exercised by short frames.
module tb_axis_len_tagger;

    localparam int MAXL = 16;

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] u;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic [15:0] out_user;
    logic        out_valid;
    logic        out_last;
    logic        trunc_pulse;
    logic [31:0] frame_cnt;
    logic [31:0] trunc_cnt;

    int checks = 0;
    int failures = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    int lens[$];
    int exp_tr;
    int npulse;

    always #5 clk = ~clk;

    axis_len_tagger #(.MAX_LEN(MAXL), .LEN_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_axis_data   (in_data),
        .i_axis_valid  (in_valid),
        .i_axis_last   (in_last),
        .o_axis_ready  (in_ready),
        .o_axis_data   (out_data),
        .o_axis_user   (out_user),
        .o_axis_valid  (out_valid),
        .o_axis_last   (out_last),
        .i_axis_ready  (out_ready),
        .o_trunc_pulse (trunc_pulse),
        .o_frame_cnt   (frame_cnt),
        .o_trunc_cnt   (trunc_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a frame of n bytes emits min(n,MAXL) beats, user 1..k, last on k
    task automatic build();
        beat_t b;
        int n;
        int e;
        exp_tr = 0;
        foreach (lens[i]) begin
            n = lens[i];
            e = (n > MAXL) ? MAXL : n;
            if (n > MAXL) exp_tr++;
            for (int j = 0; j < n; j++) begin
                b.d = 8'($urandom);
                b.u = '0;
                b.l = (j == n - 1);
                in_q.push_back(b);
                if (j < e) begin
                    b.u = 16'(j + 1);
                    b.l = (j == e - 1);
                    exp_q.push_back(b);
                end
            end
        end
        lens.delete();
    endtask

    // vm: 0 always valid, 1 random; rm: 0 always ready, 1 toggle, 2 random
    task automatic run(input int vm, input int rm);
        int cyc;
        bit vok;
        beat_t h;
        cyc = 0;
        npulse = 0;
        build();
        while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            case (rm)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2) == 1;
                default: out_ready = ($urandom % 10) < 6;
            endcase
            vok = (vm == 0) || (($urandom % 10) < 7);
            if (in_q.size() != 0 && vok) begin
                in_valid = 1'b1;
                in_data  = in_q[0].d;
                in_last  = in_q[0].l;
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
                in_last  = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    h = exp_q[0];
                    check("data", {24'd0, out_data}, {24'd0, h.d});
                    check("user", {16'd0, out_user}, {16'd0, h.u});
                    check("last", {31'd0, out_last}, {31'd0, h.l});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (trunc_pulse) npulse++;
            if (in_valid && in_ready) void'(in_q.pop_front());
        end
        check("timeout", 32'(in_q.size() + exp_q.size()), 32'd0);
        check("trunc_pulses", 32'(npulse), 32'(exp_tr));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_user", {16'd0, out_user}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_pulse", {31'd0, trunc_pulse}, 32'd0);
        check("rst_fcnt", frame_cnt, 32'd0);
        rst = 1'b0;

        lens = '{60};
        run(0, 0);
        lens = '{1, 3};
        run(0, 0);
        lens = '{20, 5};
        run(0, 0);
        lens = '{10};
        run(0, 1);
        lens = '{16, 17, 15, 1};
        run(1, 2);
        for (int i = 0; i < 30; i++) lens.push_back(int'($urandom_range(1, 40)));
        run(1, 2);

        // Reset in the middle of a frame drops it
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = 8'(i);
            in_last   = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_user", {16'd0, out_user}, 32'd10);
        check("pre_rst_data", {24'd0, out_data}, 32'd9);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_user", {16'd0, out_user}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        lens = '{5, 20, 7};
        run(0, 0);
`ifdef STATS_EN
        check("frame_cnt", frame_cnt, 32'd3);
        check("trunc_cnt", trunc_cnt, 32'd1);
`else
        check("frame_cnt", frame_cnt, 32'd0);
        check("trunc_cnt", trunc_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
